// File: rtl/reg_file_bank_pkg.sv
// Shared constants and helpers for the general-purpose register bank.
package reg_file_bank_pkg;

    localparam int          DEF_WIDTH  = 32;
    localparam int          DEF_NREGS  = 16;
    localparam int          DEF_ADDR_W = 4;
    localparam int unsigned R0_IDX     = 0;

    // True when the addressed register is the hardwired-zero R0.
    function automatic logic r0_locked(input int unsigned idx, input bit r0_zero);
        return r0_zero && (idx == R0_IDX);
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for multi-cycle producers, plus reserve acknowledge.
module reg_scoreboard
    import reg_file_bank_pkg::*;
#(
    parameter int NREGS   = DEF_NREGS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic [NREGS-1:0]  busy,
    output logic              rsv_ack
);

    logic rsv_accept;

    // A reserve of a locked R0 is dropped and not acknowledged.
    always_comb begin
        rsv_accept = rsv_en && !r0_locked(32'(rsv_addr), R0_ZERO != 0);
    end

    // Busy bits: a new reservation wins over a completing write to the same register.
    always_ff @(posedge clk) begin
        if (clr) begin
            busy    <= '0;
            rsv_ack <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (rsv_accept && (rsv_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    busy[i] <= 1'b0;
                end
            end
            rsv_ack <= rsv_accept;
        end
    end

endmodule

// File: rtl/reg_file_bank.sv
// Register bank: one write port, two registered read ports, optional R0=0,
// write-to-read bypass and a busy scoreboard.
module reg_file_bank
    import reg_file_bank_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int NREGS   = DEF_NREGS,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int R0_ZERO = 1,
    parameter int BYPASS  = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic              rsv_ack
);

    generate
        if ((1 << ADDR_W) != NREGS) begin : g_bad_addr_w
            $error("reg_file_bank: 2**ADDR_W must equal NREGS");
        end
    endgenerate

    logic [WIDTH-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [WIDTH-1:0] rd_next_a;
    logic [WIDTH-1:0] rd_next_b;
    logic             wr_ok;

    // Writes to a locked R0 are discarded.
    always_comb begin
        wr_ok = wr_en && !r0_locked(32'(wr_addr), R0_ZERO != 0);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            logic [WIDTH-1:0] q;

            // Storage for one register.
            always_ff @(posedge clk) begin
                if (clr) begin
                    q <= '0;
                end else if (wr_ok && (wr_addr == ADDR_W'(gi))) begin
                    q <= wr_data;
                end
            end

            assign regs[gi] = q;
        end
    endgenerate

    // Read muxes with optional same-cycle forwarding of the write data.
    always_comb begin
        rd_next_a = regs[rd_addr_a];
        rd_next_b = regs[rd_addr_b];
        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr_a)) begin
            rd_next_a = wr_data;
        end
        if ((BYPASS != 0) && wr_ok && (wr_addr == rd_addr_b)) begin
            rd_next_b = wr_data;
        end
    end

    // Registered read ports; a disabled port holds its last value.
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            if (rd_en_a) begin
                rd_data_a <= rd_next_a;
            end
            if (rd_en_b) begin
                rd_data_b <= rd_next_b;
            end
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .R0_ZERO(R0_ZERO)
    ) u_scoreboard (
        .clk     (clk),
        .clr     (clr),
        .rsv_en  (rsv_en),
        .rsv_addr(rsv_addr),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .busy    (busy),
        .rsv_ack (rsv_ack)
    );

    // Busy lookups reflect state before the coming edge; reads are never blocked.
    always_comb begin
        busy_a = busy[rd_addr_a];
        busy_b = busy[rd_addr_b];
    end

endmodule

// File: tb/tb_reg_file_bank.sv
// Scoreboard bench: two configurations (R0_ZERO/BYPASS = 1/1 and 0/0) share stimulus.
module tb_reg_file_bank;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en_a = 1'b0;
    logic [3:0]  rd_addr_a = '0;
    logic        rd_en_b = 1'b0;
    logic [3:0]  rd_addr_b = '0;
    logic        rsv_en = 1'b0;
    logic [3:0]  rsv_addr = '0;

    logic [31:0] rd_data_a1, rd_data_b1, rd_data_a0, rd_data_b0;
    logic        busy_a1, busy_b1, rsv_ack1, busy_a0, busy_b0, rsv_ack0;

    always #5 clk = ~clk;

    reg_file_bank #(.WIDTH(32), .NREGS(16), .ADDR_W(4), .R0_ZERO(1), .BYPASS(1)) dut1 (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a1),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_a(busy_a1), .busy_b(busy_b1), .rsv_ack(rsv_ack1)
    );

    reg_file_bank #(.WIDTH(32), .NREGS(16), .ADDR_W(4), .R0_ZERO(0), .BYPASS(0)) dut0 (
        .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a0),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b0),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_a(busy_a0), .busy_b(busy_b0), .rsv_ack(rsv_ack0)
    );

    typedef struct {
        int          due;
        logic [31:0] a1, b1, a0, b0;
        logic        k1, k0;
    } d_item_t;

    typedef struct {
        int   due;
        logic ba1, bb1, ba0, bb0;
    } b_item_t;

    d_item_t dq[$];
    b_item_t bq[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit known    = 1'b0;

    // Reference state, index 1 = R0_ZERO/BYPASS on, index 0 = both off.
    logic [31:0] m_regs [2][16];
    logic [15:0] m_busy [2];
    logic [31:0] m_rd_a [2];
    logic [31:0] m_rd_b [2];
    logic        m_ack  [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares DUT outputs against queued expectations once they fall due.
    initial begin
        forever begin
            @(negedge clk);
            while (bq.size() > 0 && bq[0].due <= cyc) begin
                b_item_t b;
                b = bq.pop_front();
                chk("busy_a_cfg1", 32'(busy_a1), 32'(b.ba1));
                chk("busy_b_cfg1", 32'(busy_b1), 32'(b.bb1));
                chk("busy_a_cfg0", 32'(busy_a0), 32'(b.ba0));
                chk("busy_b_cfg0", 32'(busy_b0), 32'(b.bb0));
            end
            while (dq.size() > 0 && dq[0].due <= cyc) begin
                d_item_t d;
                d = dq.pop_front();
                chk("rd_data_a_cfg1", rd_data_a1, d.a1);
                chk("rd_data_b_cfg1", rd_data_b1, d.b1);
                chk("rsv_ack_cfg1", 32'(rsv_ack1), 32'(d.k1));
                chk("rd_data_a_cfg0", rd_data_a0, d.a0);
                chk("rd_data_b_cfg0", rd_data_b0, d.b0);
                chk("rsv_ack_cfg0", 32'(rsv_ack0), 32'(d.k0));
            end
        end
    end

    function automatic logic [31:0] model_read(int k, logic [3:0] a, logic we, logic [3:0] wa,
                                               logic [31:0] wd);
        if (k == 1 && a == 4'd0) return 32'd0;
        if (k == 1 && we && wa == a) return wd;
        return m_regs[k][a];
    endfunction

    // Drive one cycle of inputs, advance the reference model and queue expectations.
    task automatic step(input logic c, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                        input logic rea, input logic [3:0] raa, input logic reb,
                        input logic [3:0] rab, input logic rse, input logic [3:0] rsa);
        b_item_t b;
        d_item_t d;
        @(posedge clk);
        #1;
        clr = c; wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en_a = rea; rd_addr_a = raa; rd_en_b = reb; rd_addr_b = rab;
        rsv_en = rse; rsv_addr = rsa;

        if (known) begin
            b.due = cyc;
            b.ba1 = m_busy[1][raa]; b.bb1 = m_busy[1][rab];
            b.ba0 = m_busy[0][raa]; b.bb0 = m_busy[0][rab];
            bq.push_back(b);
        end

        for (int k = 0; k < 2; k++) begin
            if (c) begin
                for (int r = 0; r < 16; r++) m_regs[k][r] = '0;
                m_busy[k] = '0; m_rd_a[k] = '0; m_rd_b[k] = '0; m_ack[k] = 1'b0;
            end else begin
                if (rea) m_rd_a[k] = model_read(k, raa, we, wa, wd);
                if (reb) m_rd_b[k] = model_read(k, rab, we, wa, wd);
                m_ack[k] = rse && !(k == 1 && rsa == 4'd0);
                if (we) begin
                    if (!(k == 1 && wa == 4'd0)) m_regs[k][wa] = wd;
                    m_busy[k][wa] = 1'b0;
                end
                if (m_ack[k]) m_busy[k][rsa] = 1'b1;
            end
        end
        if (c) known = 1'b1;

        if (known) begin
            d.due = cyc + 1;
            d.a1 = m_rd_a[1]; d.b1 = m_rd_b[1]; d.k1 = m_ack[1];
            d.a0 = m_rd_a[0]; d.b0 = m_rd_b[0]; d.k0 = m_ack[0];
            dq.push_back(d);
        end
    endtask

    function automatic logic [3:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 4'($urandom_range(0, 15));
        return 4'($urandom_range(0, 4));
    endfunction

    initial begin
        //   clr we wa  wd            rea raa reb rab rse rsa
        step(1, 0, 0, 0,            0, 0, 0, 0, 0, 0);
        // reset clears a written register
        step(0, 1, 3, 5,            0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0,            0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0,            1, 3, 0, 0, 0, 0);
        // write then read
        step(0, 1, 3, 5,            0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0,            1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0,            0, 3, 0, 0, 0, 0);
        // bypass on both ports
        step(0, 1, 7, 32'h11,       0, 0, 0, 0, 0, 0);
        step(0, 1, 7, 32'hAA,       1, 7, 1, 7, 0, 0);
        step(0, 0, 0, 0,            1, 7, 1, 7, 0, 0);
        // R0 write, read and reserve
        step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0,            1, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0,            0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0,            0, 0, 0, 0, 0, 0);
        // scoreboard reserve, clear by write, reserve+write
        step(0, 0, 0, 0,            0, 4, 0, 0, 1, 4);
        step(0, 0, 0, 0,            0, 4, 0, 4, 1, 4);
        step(0, 1, 4, 32'h44,       0, 4, 0, 0, 0, 0);
        step(0, 0, 0, 0,            0, 4, 0, 0, 0, 0);
        step(0, 1, 4, 32'h45,       0, 4, 0, 0, 1, 4);
        step(0, 0, 0, 0,            1, 4, 0, 4, 0, 0);
        // clr overrides write and reserve of R2
        step(0, 1, 2, 32'h22,       0, 0, 0, 0, 1, 5);
        step(1, 1, 2, 32'h99,       0, 2, 0, 5, 1, 2);
        step(0, 0, 0, 0,            1, 2, 1, 5, 0, 0);
        step(0, 0, 0, 0,            0, 2, 0, 5, 0, 0);

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                 1'($urandom_range(0, 1)), rnd_addr(),
                 1'($urandom_range(0, 1)), rnd_addr(),
                 ($urandom_range(0, 3) == 0), rnd_addr());
        end

        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("drain_data_queue", 32'(dq.size()), 32'd0);
        chk("drain_busy_queue", 32'(bq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
